// File: rtl/hilo_mdu_if.sv
// Decoder/EX-stage request bus and HI/LO write-back bus of the multiply/divide unit.
interface hilo_mdu_if;
  localparam int unsigned DW = 32;

  logic          start;
  logic [2:0]    op;
  logic [DW-1:0] src_a;
  logic [DW-1:0] src_b;
  logic          flush;
  logic          stall_req;
  logic          busy;
  logic          hi_we;
  logic          lo_we;
  logic [DW-1:0] hi_wdata;
  logic [DW-1:0] lo_wdata;

  modport master (
    output start, op, src_a, src_b, flush,
    input  stall_req, busy, hi_we, lo_we, hi_wdata, lo_wdata
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output stall_req, busy, hi_we, lo_we, hi_wdata, lo_wdata
  );
endinterface

// File: rtl/hilo_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO producer for the HI/LO register pair.
// Optional HILO_MDU_FAST_MUL_EN: single-cycle combinational multiply, division unchanged.
module hilo_mdu #(
  parameter int unsigned ITER_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  hilo_mdu_if.slave  bus
);
  localparam int unsigned DW    = 32;
  localparam int unsigned PW    = 2 * DW;
  localparam int unsigned CNT_W = $clog2(ITER_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [PW-1:0]    acc_q;
  logic [DW:0]      rem_q;
  logic [DW-1:0]    opnd_q;
  logic [DW-1:0]    dvd_raw_q;
  logic             neg_res_q, neg_rem_q, div_zero_q;

  logic             hi_we_q, lo_we_q, hi_we_d, lo_we_d;
  logic [DW-1:0]    hi_wdata_q, lo_wdata_q, hi_wdata_d, lo_wdata_d;

  // Request decode and operand conditioning
  logic          is_mul, is_div, op_signed, a_neg, b_neg, accept, last_iter;
  logic [DW-1:0] a_mag, b_mag;

  assign is_mul    = (bus.op == OP_MULT) | (bus.op == OP_MULTU);
  assign is_div    = (bus.op == OP_DIV)  | (bus.op == OP_DIVU);
  assign op_signed = (bus.op == OP_MULT) | (bus.op == OP_DIV);
  assign a_neg     = op_signed & bus.src_a[DW-1];
  assign b_neg     = op_signed & bus.src_b[DW-1];
  assign a_mag     = a_neg ? -bus.src_a : bus.src_a;
  assign b_mag     = b_neg ? -bus.src_b : bus.src_b;
  assign accept    = (state_q == S_IDLE) & bus.start & ~bus.flush;
  assign last_iter = (cnt_q == CNT_W'(ITER_CYCLES - 1));

  // Shift-add step: acc = {partial product, remaining multiplier bits}
  logic [DW:0]   mul_sum;
  logic [PW-1:0] mul_next, mul_res;

  assign mul_sum  = {1'b0, acc_q[PW-1:DW]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[DW-1:1]};
  assign mul_res  = neg_res_q ? -mul_next : mul_next;

  // Restoring step: acc low half shifts dividend out and quotient bits in
  logic [DW+1:0] div_trial;
  logic          div_ok;
  logic [DW:0]   rem_next;
  logic [DW-1:0] quo_next;

  assign div_trial = {rem_q, acc_q[DW-1]} - {2'b00, opnd_q};
  assign div_ok    = ~div_trial[DW+1];
  assign rem_next  = div_ok ? div_trial[DW:0] : {rem_q[DW-1:0], acc_q[DW-1]};
  assign quo_next  = {acc_q[DW-2:0], div_ok};

`ifdef HILO_MDU_FAST_MUL_EN
  logic [PW-1:0] fast_prod;
  assign fast_prod = {{DW{a_neg}}, bus.src_a} * {{DW{b_neg}}, bus.src_b};
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && is_mul) begin
`ifdef HILO_MDU_FAST_MUL_EN
          state_d = S_DONE;
`else
          state_d = S_MUL;
`endif
        end else if (accept && is_div) begin
          state_d = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        if (bus.flush)      state_d = S_IDLE;
        else if (last_iter) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: stall/busy plus next values of the write-back registers
  always_comb begin
    bus.stall_req = rst & ((accept & (is_mul | is_div)) |
                           (state_q == S_MUL) | (state_q == S_DIV));
    bus.busy      = (state_q != S_IDLE);
    hi_we_d       = 1'b0;
    lo_we_d       = 1'b0;
    hi_wdata_d    = hi_wdata_q;
    lo_wdata_d    = lo_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept && bus.op == OP_MTHI) begin
          hi_we_d    = 1'b1;
          hi_wdata_d = bus.src_a;
        end else if (accept && bus.op == OP_MTLO) begin
          lo_we_d    = 1'b1;
          lo_wdata_d = bus.src_a;
        end
`ifdef HILO_MDU_FAST_MUL_EN
        else if (accept && is_mul) begin
          hi_we_d    = 1'b1;
          lo_we_d    = 1'b1;
          hi_wdata_d = fast_prod[PW-1:DW];
          lo_wdata_d = fast_prod[DW-1:0];
        end
`endif
      end
      S_MUL: begin
        if (last_iter && !bus.flush) begin
          hi_we_d    = 1'b1;
          lo_we_d    = 1'b1;
          hi_wdata_d = mul_res[PW-1:DW];
          lo_wdata_d = mul_res[DW-1:0];
        end
      end
      S_DIV: begin
        if (last_iter && !bus.flush) begin
          hi_we_d = 1'b1;
          lo_we_d = 1'b1;
          // Divide by zero returns all-ones quotient and the raw dividend
          if (div_zero_q) begin
            hi_wdata_d = dvd_raw_q;
            lo_wdata_d = '1;
          end else begin
            hi_wdata_d = neg_rem_q ? -rem_next[DW-1:0] : rem_next[DW-1:0];
            lo_wdata_d = neg_res_q ? -quo_next : quo_next;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and write-back registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      opnd_q     <= '0;
      dvd_raw_q  <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_we_q    <= 1'b0;
      lo_we_q    <= 1'b0;
      hi_wdata_q <= '0;
      lo_wdata_q <= '0;
    end else begin
      hi_we_q    <= hi_we_d;
      lo_we_q    <= lo_we_d;
      hi_wdata_q <= hi_wdata_d;
      lo_wdata_q <= lo_wdata_d;
      case (state_q)
        S_IDLE: begin
          if (accept && (is_mul || is_div)) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            neg_res_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            dvd_raw_q  <= bus.src_a;
            div_zero_q <= (bus.src_b == '0);
            if (is_mul) begin
              opnd_q <= a_mag;
              acc_q  <= {DW'(0), b_mag};
            end else begin
              opnd_q <= b_mag;
              acc_q  <= {DW'(0), a_mag};
            end
          end
        end
        S_MUL: begin
          cnt_q <= bus.flush ? '0 : cnt_q + CNT_W'(1);
          acc_q <= mul_next;
        end
        S_DIV: begin
          cnt_q <= bus.flush ? '0 : cnt_q + CNT_W'(1);
          acc_q <= {acc_q[PW-1:DW], quo_next};
          rem_q <= rem_next;
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  // A flush in the write cycle suppresses the HI/LO update
  assign bus.hi_we    = hi_we_q & ~bus.flush;
  assign bus.lo_we    = lo_we_q & ~bus.flush;
  assign bus.hi_wdata = hi_wdata_q;
  assign bus.lo_wdata = lo_wdata_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu: directed and randomized ops against an arithmetic reference.
module tb_hilo_mdu;
  localparam int MAX_WAIT = 60;
`ifdef HILO_MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  hilo_mdu_if mdu_bus();

  hilo_mdu dut (
    .clk (clk),
    .rst (rst),
    .bus (mdu_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference: plain 64-bit arithmetic with the HI/LO architectural rules
  function automatic void ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
    longint          sp, sq, sr;
    longint unsigned up;
    hi = '0;
    lo = '0;
    case (op)
      OP_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        hi = sp[63:32]; lo = sp[31:0];
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        hi = up[63:32]; lo = up[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF; hi = a;
        end else if (op == OP_DIV) begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          lo = sq[31:0]; hi = sr[31:0];
        end else begin
          lo = a / b; hi = a % b;
        end
      end
      OP_MTHI: hi = a;
      OP_MTLO: lo = a;
      default: ;
    endcase
  endfunction

  // Drives one request and waits (bounded) for the write cycle
  task automatic issue_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int stalls, output logic stall_w,
                          output logic hw, output logic lw, output logic [31:0] hd, output logic [31:0] ld);
    @(negedge clk);
    mdu_bus.start = 1'b1; mdu_bus.op = op; mdu_bus.src_a = a; mdu_bus.src_b = b; mdu_bus.flush = 1'b0;
    #1;
    stalls = int'(mdu_bus.stall_req);
    @(negedge clk);
    mdu_bus.start = 1'b0; mdu_bus.src_a = $urandom; mdu_bus.src_b = $urandom;
    #1;
    lat = 1;
    while (!(mdu_bus.hi_we || mdu_bus.lo_we) && lat < MAX_WAIT) begin
      stalls += int'(mdu_bus.stall_req);
      @(negedge clk); #1;
      lat++;
    end
    stall_w = mdu_bus.stall_req;
    hw = mdu_bus.hi_we; lw = mdu_bus.lo_we;
    hd = mdu_bus.hi_wdata; ld = mdu_bus.lo_wdata;
  endtask

  task automatic test_reset();
    mdu_bus.start = 1'b0; mdu_bus.op = '0; mdu_bus.src_a = '0; mdu_bus.src_b = '0; mdu_bus.flush = 1'b0;
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({mdu_bus.stall_req, mdu_bus.busy, mdu_bus.hi_we, mdu_bus.lo_we, mdu_bus.hi_wdata, mdu_bus.lo_wdata} !== 68'd0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b%b busy=%b stall=%b hi=%h lo=%h, want all zero",
               mdu_bus.hi_we, mdu_bus.lo_we, mdu_bus.busy, mdu_bus.stall_req, mdu_bus.hi_wdata, mdu_bus.lo_wdata);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mthi_mtlo();
    int lat, stalls; logic sw, hw, lw; logic [31:0] hd, ld;
    issue_op(OP_MTHI, 32'hDEAD_BEEF, 32'h0, lat, stalls, sw, hw, lw, hd, ld);
    checks++;
    if (lat !== 1 || stalls !== 0 || sw !== 1'b0 || hw !== 1'b1 || lw !== 1'b0 || hd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL mthi: got lat=%0d stalls=%0d hw=%b lw=%b hi=%h, want lat=1 stalls=0 hw=1 lw=0 hi=deadbeef",
               lat, stalls, hw, lw, hd);
    end
    issue_op(OP_MTLO, 32'h0000_0055, 32'h0, lat, stalls, sw, hw, lw, hd, ld);
    checks++;
    if (lat !== 1 || stalls !== 0 || sw !== 1'b0 || hw !== 1'b0 || lw !== 1'b1 || ld !== 32'h55) begin
      errors++;
      $display("FAIL mtlo: got lat=%0d stalls=%0d hw=%b lw=%b lo=%h, want lat=1 stalls=0 hw=0 lw=1 lo=00000055",
               lat, stalls, hw, lw, ld);
    end
    @(negedge clk); #1;
    checks++;
    if (mdu_bus.hi_we !== 1'b0 || mdu_bus.lo_we !== 1'b0 || mdu_bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mt_single_pulse: got hw=%b lw=%b busy=%b, want 0 0 0", mdu_bus.hi_we, mdu_bus.lo_we, mdu_bus.busy);
    end
  endtask

  task automatic test_mul();
    logic [2:0]  dop [4] = '{OP_MULT, OP_MULTU, OP_MULT, OP_MULTU};
    logic [31:0] da  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd6, 32'hFFFF_FFFF};
    logic [31:0] db  [4] = '{32'h2, 32'h2, 32'd7, 32'hFFFF_FFFF};
    logic [31:0] dhi [4] = '{32'hFFFF_FFFF, 32'h1, 32'h0, 32'hFFFF_FFFE};
    logic [31:0] dlo [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd42, 32'h1};
    int lat, stalls; logic sw, hw, lw; logic [31:0] hd, ld, a, b, ehi, elo; logic [2:0] op;
    for (int i = 0; i < 12; i++) begin
      if (i < 4) begin
        op = dop[i]; a = da[i]; b = db[i]; ehi = dhi[i]; elo = dlo[i];
      end else begin
        op = 3'($urandom_range(0, 1)); a = $urandom; b = $urandom;
        ref_mdu(op, a, b, ehi, elo);
      end
      issue_op(op, a, b, lat, stalls, sw, hw, lw, hd, ld);
      checks++;
      if (lat !== MUL_LAT || stalls !== MUL_LAT || sw !== 1'b0 || hw !== 1'b1 || lw !== 1'b1) begin
        errors++;
        $display("FAIL mul_timing[%0d]: got lat=%0d stalls=%0d stall_at_write=%b we=%b%b, want lat=%0d stalls=%0d 0 11",
                 i, lat, stalls, sw, hw, lw, MUL_LAT, MUL_LAT);
      end
      checks++;
      if (hd !== ehi || ld !== elo) begin
        errors++;
        $display("FAIL mul_result[%0d] op=%0d a=%h b=%h: got hi=%h lo=%h, want hi=%h lo=%h", i, op, a, b, hd, ld, ehi, elo);
      end
      @(negedge clk); #1;
      checks++;
      if (mdu_bus.busy !== 1'b0 || mdu_bus.hi_we !== 1'b0 || mdu_bus.lo_we !== 1'b0) begin
        errors++;
        $display("FAIL mul_idle_after[%0d]: got busy=%b we=%b%b, want 0 00", i, mdu_bus.busy, mdu_bus.hi_we, mdu_bus.lo_we);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  dop [5] = '{OP_DIVU, OP_DIV, OP_DIV, OP_DIVU, OP_DIV};
    logic [31:0] da  [5] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'h1234, 32'hFFFF_FFF0};
    logic [31:0] db  [5] = '{32'd7, 32'h2, 32'hFFFF_FFFF, 32'h0, 32'h0};
    logic [31:0] dhi [5] = '{32'h2, 32'hFFFF_FFFF, 32'h0, 32'h1234, 32'hFFFF_FFF0};
    logic [31:0] dlo [5] = '{32'hE, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    int lat, stalls; logic sw, hw, lw; logic [31:0] hd, ld, a, b, ehi, elo; logic [2:0] op;
    for (int i = 0; i < 14; i++) begin
      if (i < 5) begin
        op = dop[i]; a = da[i]; b = db[i]; ehi = dhi[i]; elo = dlo[i];
      end else begin
        op = 3'($urandom_range(2, 3)); a = $urandom;
        case ($urandom_range(0, 3))
          0:       b = 32'd0;
          1:       b = $urandom_range(1, 50);
          2:       b = -32'($urandom_range(1, 50));
          default: b = $urandom;
        endcase
        ref_mdu(op, a, b, ehi, elo);
      end
      issue_op(op, a, b, lat, stalls, sw, hw, lw, hd, ld);
      checks++;
      if (lat !== DIV_LAT || stalls !== DIV_LAT || sw !== 1'b0 || hw !== 1'b1 || lw !== 1'b1) begin
        errors++;
        $display("FAIL div_timing[%0d]: got lat=%0d stalls=%0d stall_at_write=%b we=%b%b, want lat=%0d stalls=%0d 0 11",
                 i, lat, stalls, sw, hw, lw, DIV_LAT, DIV_LAT);
      end
      checks++;
      if (hd !== ehi || ld !== elo) begin
        errors++;
        $display("FAIL div_result[%0d] op=%0d a=%h b=%h: got hi=%h lo=%h, want hi=%h lo=%h", i, op, a, b, hd, ld, ehi, elo);
      end
    end
  endtask

  task automatic test_undefined_op();
    int seen;
    for (int op = 6; op < 8; op++) begin
      seen = 0;
      @(negedge clk);
      mdu_bus.start = 1'b1; mdu_bus.op = 3'(op); mdu_bus.src_a = $urandom; mdu_bus.src_b = $urandom;
      #1;
      seen += int'(mdu_bus.stall_req);
      @(negedge clk); mdu_bus.start = 1'b0;
      repeat (3) begin
        #1;
        seen += int'(mdu_bus.hi_we) + int'(mdu_bus.lo_we) + int'(mdu_bus.busy) + int'(mdu_bus.stall_req);
        @(negedge clk);
      end
      checks++;
      if (seen !== 0) begin
        errors++;
        $display("FAIL undefined_op[%0d]: got %0d activity samples, want 0", op, seen);
      end
    end
  endtask

  task automatic test_flush();
    int lat, stalls, seen; logic sw, hw, lw; logic [31:0] hd, ld;
    // Flush during division iterations
    @(negedge clk);
    mdu_bus.start = 1'b1; mdu_bus.op = OP_DIV; mdu_bus.src_a = 32'd1000; mdu_bus.src_b = 32'd3;
    @(negedge clk); mdu_bus.start = 1'b0;
    repeat (9) @(negedge clk);
    mdu_bus.flush = 1'b1;
    #1;
    checks++;
    if (mdu_bus.hi_we !== 1'b0 || mdu_bus.lo_we !== 1'b0 || mdu_bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_div_during: got we=%b%b busy=%b, want 00 1", mdu_bus.hi_we, mdu_bus.lo_we, mdu_bus.busy);
    end
    @(negedge clk); mdu_bus.flush = 1'b0;
    #1;
    checks++;
    if (mdu_bus.busy !== 1'b0 || mdu_bus.stall_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_div_idle: got busy=%b stall=%b, want 0 0", mdu_bus.busy, mdu_bus.stall_req);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk); #1;
      seen += int'(mdu_bus.hi_we) + int'(mdu_bus.lo_we);
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL flush_div_no_write: got %0d write samples, want 0", seen);
    end
    issue_op(OP_MULTU, 32'd3, 32'd5, lat, stalls, sw, hw, lw, hd, ld);
    checks++;
    if (lat !== MUL_LAT || hw !== 1'b1 || lw !== 1'b1 || hd !== 32'd0 || ld !== 32'd15) begin
      errors++;
      $display("FAIL flush_then_multu: got lat=%0d we=%b%b hi=%h lo=%h, want lat=%0d 11 hi=0 lo=f", lat, hw, lw, hd, ld, MUL_LAT);
    end
    // Flush in the write cycle cancels the write
    @(negedge clk);
    mdu_bus.start = 1'b1; mdu_bus.op = OP_MULT; mdu_bus.src_a = 32'd6; mdu_bus.src_b = 32'd7;
    @(negedge clk); mdu_bus.start = 1'b0;
    repeat (MUL_LAT - 1) @(negedge clk);
    #1;
    checks++;
    if (mdu_bus.lo_we !== 1'b1) begin
      errors++;
      $display("FAIL flush_done_reach: got lo_we=%b, want 1", mdu_bus.lo_we);
    end
    mdu_bus.flush = 1'b1;
    #1;
    checks++;
    if (mdu_bus.hi_we !== 1'b0 || mdu_bus.lo_we !== 1'b0) begin
      errors++;
      $display("FAIL flush_done_gate: got we=%b%b, want 00", mdu_bus.hi_we, mdu_bus.lo_we);
    end
    // Start together with flush is ignored
    @(negedge clk);
    mdu_bus.start = 1'b1; mdu_bus.op = OP_DIVU; mdu_bus.src_a = 32'd9; mdu_bus.src_b = 32'd2;
    #1;
    checks++;
    if (mdu_bus.stall_req !== 1'b0 || mdu_bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_start_stall: got stall=%b busy=%b, want 0 0", mdu_bus.stall_req, mdu_bus.busy);
    end
    @(negedge clk); mdu_bus.start = 1'b0; mdu_bus.flush = 1'b0;
    #1;
    checks++;
    if (mdu_bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_start_ignored: got busy=%b, want 0", mdu_bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    mdu_bus.start = 1'b1; mdu_bus.op = OP_MULT; mdu_bus.src_a = 32'h1234_5678; mdu_bus.src_b = 32'h9ABC_DEF0;
    @(negedge clk); mdu_bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({mdu_bus.stall_req, mdu_bus.busy, mdu_bus.hi_we, mdu_bus.lo_we, mdu_bus.hi_wdata, mdu_bus.lo_wdata} !== 68'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got we=%b%b busy=%b stall=%b hi=%h lo=%h, want all zero",
               mdu_bus.hi_we, mdu_bus.lo_we, mdu_bus.busy, mdu_bus.stall_req, mdu_bus.hi_wdata, mdu_bus.lo_wdata);
    end
    @(negedge clk); rst = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk); #1;
      seen += int'(mdu_bus.hi_we) + int'(mdu_bus.lo_we) + int'(mdu_bus.busy);
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_write: got %0d activity samples, want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int lat, stalls, elat, estall; logic sw, hw, lw; logic [31:0] hd, ld, a, b, ehi, elo; logic [2:0] op;
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(0, 5)); a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      ref_mdu(op, a, b, ehi, elo);
      elat   = (op <= OP_MULTU) ? MUL_LAT : (op <= OP_DIVU) ? DIV_LAT : 1;
      estall = (op >= OP_MTHI) ? 0 : elat;
      issue_op(op, a, b, lat, stalls, sw, hw, lw, hd, ld);
      checks++;
      if (lat !== elat || stalls !== estall || hw !== (op != OP_MTLO) || lw !== (op != OP_MTHI) ||
          (hw && hd !== ehi) || (lw && ld !== elo)) begin
        errors++;
        $display("FAIL b2b[%0d] op=%0d a=%h b=%h: got lat=%0d stalls=%0d we=%b%b hi=%h lo=%h, want lat=%0d stalls=%0d hi=%h lo=%h",
                 i, op, a, b, lat, stalls, hw, lw, hd, ld, elat, estall, ehi, elo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_mul();
    test_div();
    test_undefined_op();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
